// File: rtl/y86_seq_sequencer_if.sv
// y86_seq_sequencer_if: control/status bundle between the SEQ datapath and its sequencer.
interface y86_seq_sequencer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  halt;
    logic                  instr_valid;
    logic                  imem_error;
    logic                  dmem_error;
    logic                  mem_stall;
    logic [ADDR_WIDTH-1:0] pc;
    logic [4:0]            stage_en;
    logic [1:0]            stat;
    logic                  running;
    logic [CNT_WIDTH-1:0]  cycle_count;
    logic [CNT_WIDTH-1:0]  instr_count;

    modport master (
        output start, next_pc, halt, instr_valid, imem_error, dmem_error, mem_stall,
        input  pc, stage_en, stat, running, cycle_count, instr_count
    );

    modport slave (
        input  start, next_pc, halt, instr_valid, imem_error, dmem_error, mem_stall,
        output pc, stage_en, stat, running, cycle_count, instr_count
    );
endinterface

// File: rtl/y86_seq_sequencer.sv
// y86_seq_sequencer: owns the PC, strobes fetch..writeback, records Y86 status and run counters.
module y86_seq_sequencer #(
    parameter int                    ADDR_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter int                    CNT_WIDTH    = 32,
    parameter bit                    SINGLE_CYCLE = 1'b0
) (
    input logic clk,
    input logic reset,
    y86_seq_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, STOPPED, RUN} state_t;
    localparam logic [1:0] AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [1:0]            stat, stat_n;
    logic [CNT_WIDTH-1:0]  cyc, cyc_n, cyc_inc, ins, ins_n, ins_inc;
    logic                  halt_q, halt_n, running;

    assign running = state != IDLE && state != STOPPED;
    assign cyc_inc = &cyc ? cyc : cyc + 1'b1;
    assign ins_inc = &ins ? ins : ins + 1'b1;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        stat_n  = stat;
        cyc_n   = running ? cyc_inc : cyc;
        ins_n   = ins;
        halt_n  = halt_q;
        case (state)
            IDLE, STOPPED: if (bus.start) begin
                if (SINGLE_CYCLE) state_n = RUN;
                else state_n = FETCH;
                pc_n   = RESET_PC;
                stat_n = AOK;
                cyc_n  = '0;
                ins_n  = '0;
                halt_n = 1'b0;
            end
            FETCH: if (bus.imem_error) begin
                stat_n  = ADR;
                state_n = STOPPED;
            end else if (!bus.instr_valid) begin
                stat_n  = INS;
                state_n = STOPPED;
            end else begin
                state_n = DECODE;
                halt_n  = bus.halt;
            end
            DECODE:  state_n = EXECUTE;
            EXECUTE: state_n = MEMORY;
            // dmem_error only means something once the memory has answered
            MEMORY: if (!bus.mem_stall) begin
                if (bus.dmem_error) begin
                    stat_n  = ADR;
                    state_n = STOPPED;
                end else state_n = WRITEBACK;
            end
            WRITEBACK: begin
                ins_n  = ins_inc;
                halt_n = 1'b0;
                if (halt_q) begin
                    stat_n  = HLT;
                    state_n = STOPPED;
                end else begin
                    pc_n    = bus.next_pc;
                    state_n = FETCH;
                end
            end
            RUN: if (bus.imem_error) begin
                stat_n  = ADR;
                state_n = STOPPED;
            end else if (!bus.instr_valid) begin
                stat_n  = INS;
                state_n = STOPPED;
            end else if (!bus.mem_stall) begin
                if (bus.dmem_error) begin
                    stat_n  = ADR;
                    state_n = STOPPED;
                end else begin
                    ins_n = ins_inc;
                    if (bus.halt) begin
                        stat_n  = HLT;
                        state_n = STOPPED;
                    end else pc_n = bus.next_pc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            stat   <= AOK;
            cyc    <= '0;
            ins    <= '0;
            halt_q <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            stat   <= stat_n;
            cyc    <= cyc_n;
            ins    <= ins_n;
            halt_q <= halt_n;
        end
    end

    assign bus.pc          = pc;
    assign bus.stat        = stat;
    assign bus.running     = running;
    assign bus.cycle_count = cyc;
    assign bus.instr_count = ins;
    assign bus.stage_en    = state == RUN       ? 5'b11111 :
                             state == FETCH     ? 5'b00001 :
                             state == DECODE    ? 5'b00010 :
                             state == EXECUTE   ? 5'b00100 :
                             state == MEMORY    ? 5'b01000 :
                             state == WRITEBACK ? 5'b10000 : 5'b00000;
endmodule

// File: tb/tb_y86_seq_sequencer.sv
// tb_y86_seq_sequencer: random programs on a multi-cycle and a single-cycle sequencer, scoreboarded per clock.
module tb_y86_seq_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] npc;
        bit          halt, imem, inv, dmem;
        int          stall;
    } ins_t;

    int n_chk = 0, n_fail = 0;
    ins_t prog[$];
    logic [135:0] q0[$], q1[$];

    logic        st[2], hl[2], iv[2], ie[2], de[2], ms[2];
    logic [63:0] np[2];
    logic [4:0]  o_se[2];
    logic [63:0] o_pc[2];
    logic [1:0]  o_st[2];
    logic        o_run[2];
    logic [31:0] o_cyc[2], o_ins[2];

    y86_seq_sequencer_if #(.ADDR_WIDTH(64), .CNT_WIDTH(32)) mc_if();
    y86_seq_sequencer_if #(.ADDR_WIDTH(16), .CNT_WIDTH(4))  sc_if();

    y86_seq_sequencer #(.ADDR_WIDTH(64), .RESET_PC(64'h0), .CNT_WIDTH(32), .SINGLE_CYCLE(1'b0))
        u_mc (.clk(clk), .reset(reset), .bus(mc_if));
    y86_seq_sequencer #(.ADDR_WIDTH(16), .RESET_PC(16'h0040), .CNT_WIDTH(4), .SINGLE_CYCLE(1'b1))
        u_sc (.clk(clk), .reset(reset), .bus(sc_if));

    assign mc_if.start = st[0];
    assign mc_if.halt = hl[0];
    assign mc_if.instr_valid = iv[0];
    assign mc_if.imem_error = ie[0];
    assign mc_if.dmem_error = de[0];
    assign mc_if.mem_stall = ms[0];
    assign mc_if.next_pc = np[0];
    assign sc_if.start = st[1];
    assign sc_if.halt = hl[1];
    assign sc_if.instr_valid = iv[1];
    assign sc_if.imem_error = ie[1];
    assign sc_if.dmem_error = de[1];
    assign sc_if.mem_stall = ms[1];
    assign sc_if.next_pc = np[1][15:0];
    assign o_se[0] = mc_if.stage_en;
    assign o_pc[0] = mc_if.pc;
    assign o_st[0] = mc_if.stat;
    assign o_run[0] = mc_if.running;
    assign o_cyc[0] = mc_if.cycle_count;
    assign o_ins[0] = mc_if.instr_count;
    assign o_se[1] = sc_if.stage_en;
    assign o_pc[1] = {48'b0, sc_if.pc};
    assign o_st[1] = sc_if.stat;
    assign o_run[1] = sc_if.running;
    assign o_cyc[1] = {28'b0, sc_if.cycle_count};
    assign o_ins[1] = {28'b0, sc_if.instr_count};

    function automatic logic [135:0] pk(logic [4:0] se, logic [63:0] pc, logic [1:0] s, logic r,
                                        logic [31:0] c, logic [31:0] n);
        return {se, pc, s, r, c, n};
    endfunction

    function automatic logic [135:0] outs(int m);
        return pk(o_se[m], o_pc[m], o_st[m], o_run[m], o_cyc[m], o_ins[m]);
    endfunction

    function automatic void chk(string nm, logic [135:0] a, logic [135:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endfunction

    function automatic logic [63:0] rpc(int m);
        return m != 0 ? 64'h40 : 64'h0;
    endfunction

    function automatic logic [63:0] amask(int m);
        return m != 0 ? 64'hFFFF : '1;
    endfunction

    function automatic logic [31:0] sat(logic [31:0] v, int m);
        return v == (m != 0 ? 32'hF : 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // Monitor: compares every clock the sequencer runs, plus the clock where it stops.
    bit prev[2];
    logic [135:0] mon_exp;
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (o_run[m] || prev[m]) begin
                if ((m != 0 ? q1.size() : q0.size()) == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL trace%0d: output %h with nothing expected", m, outs(m));
                end else begin
                    if (m != 0) mon_exp = q1.pop_front();
                    else mon_exp = q0.pop_front();
                    chk($sformatf("trace%0d", m), outs(m), mon_exp);
                end
            end
            prev[m] = o_run[m];
        end
    end

    task automatic push(int m, logic [4:0] se, logic [63:0] pc, logic [1:0] s, logic r,
                        logic [31:0] c, logic [31:0] n);
        if (m != 0) q1.push_back(pk(se, pc, s, r, c, n));
        else q0.push_back(pk(se, pc, s, r, c, n));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic garbage(int m);
        np[m] = {$urandom, $urandom} & amask(m);
        {st[m], hl[m], iv[m], ie[m], de[m], ms[m]} = 6'($urandom);
    endtask

    task automatic step(input int m, input logic [4:0] se, input logic [63:0] pc, input logic [1:0] s,
                        inout logic [31:0] c, input logic [31:0] n);
        push(m, se, pc, s, 1'b1, c, n);
        tick;
        c = sat(c, m);
    endtask

    task automatic add(logic [63:0] npc, bit h, bit im, bit inv, bit dm, int stl);
        ins_t t;
        t.npc = npc;
        t.halt = h;
        t.imem = im;
        t.inv = inv;
        t.dmem = dm;
        t.stall = stl;
        prog.push_back(t);
    endtask

    task automatic gen(int m, int len);
        prog.delete();
        for (int i = 0; i < len; i++)
            add({$urandom, $urandom} & amask(m), i == len - 1, $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    endtask

    // Reference model: per instruction, lays out the clocks it should take and the architectural result.
    task automatic run_prog(int m);
        logic [63:0] pc;
        logic [1:0]  s;
        logic [31:0] c, n;
        bit          stop;
        ins_t        t;
        pc = rpc(m);
        s = 2'd0;
        c = 0;
        n = 0;
        stop = 0;
        garbage(m);
        st[m] = 1'b1;
        tick;
        foreach (prog[i]) if (!stop) begin
            t = prog[i];
            if (m == 0) begin
                garbage(0);
                ie[0] = t.imem; iv[0] = !t.inv; hl[0] = t.halt; de[0] = t.dmem;
                step(0, 5'b00001, pc, s, c, n);
                if (t.imem || t.inv) begin
                    s = t.imem ? 2'd2 : 2'd3;
                    stop = 1;
                end else begin
                    garbage(0);
                    step(0, 5'b00010, pc, s, c, n);
                    garbage(0);
                    step(0, 5'b00100, pc, s, c, n);
                    repeat (t.stall) begin
                        garbage(0);
                        ms[0] = 1'b1;
                        step(0, 5'b01000, pc, s, c, n);
                    end
                    garbage(0);
                    ms[0] = 1'b0; de[0] = t.dmem;
                    step(0, 5'b01000, pc, s, c, n);
                    if (t.dmem) begin
                        s = 2'd2;
                        stop = 1;
                    end else begin
                        garbage(0);
                        np[0] = t.npc;
                        step(0, 5'b10000, pc, s, c, n);
                        n = sat(n, 0);
                        if (t.halt) begin
                            s = 2'd1;
                            stop = 1;
                        end else pc = t.npc;
                    end
                end
            end else begin
                repeat (t.stall) begin
                    garbage(1);
                    ie[1] = 1'b0; iv[1] = 1'b1; ms[1] = 1'b1;
                    step(1, 5'b11111, pc, s, c, n);
                end
                garbage(1);
                ie[1] = t.imem; iv[1] = !t.inv; ms[1] = 1'b0; de[1] = t.dmem; hl[1] = t.halt; np[1] = t.npc;
                step(1, 5'b11111, pc, s, c, n);
                stop = 1;
                if (t.imem) s = 2'd2;
                else if (t.inv) s = 2'd3;
                else if (t.dmem) s = 2'd2;
                else begin
                    n = sat(n, 1);
                    if (t.halt) s = 2'd1;
                    else begin
                        pc = t.npc;
                        stop = 0;
                    end
                end
            end
        end
        st[m] = 1'b0;
        push(m, 5'b0, pc, s, 1'b0, c, n);
        tick;
    endtask

    initial begin
        logic [63:0] pc;
        logic [31:0] c, n;
        for (int m = 0; m < 2; m++) begin
            {st[m], hl[m], iv[m], ie[m], de[m], ms[m]} = 6'b0;
            np[m] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mc", outs(0), pk(0, 64'h0, 0, 0, 0, 0));
        chk("reset_sc", outs(1), pk(0, 64'h40, 0, 0, 0, 0));
        reset = 1'b0;
        tick;

        prog.delete(); add(64'h0A, 0, 0, 0, 0, 0); add(64'h99, 1, 0, 0, 0, 0);
        run_prog(0);
        chk("mc_halt", outs(0), pk(0, 64'h0A, 1, 0, 10, 2));
        prog.delete(); add(64'h20, 0, 0, 0, 0, 3); add(64'h0, 1, 0, 0, 0, 0);
        run_prog(0);
        chk("mc_stall", outs(0), pk(0, 64'h20, 1, 0, 13, 2));
        prog.delete(); add(64'h8, 0, 0, 1, 1, 0);
        run_prog(0);
        chk("mc_ins_over_dmem", outs(0), pk(0, 64'h0, 3, 0, 1, 0));
        prog.delete(); add(64'h8, 0, 0, 0, 1, 2);
        run_prog(0);
        chk("mc_dmem", outs(0), pk(0, 64'h0, 2, 0, 6, 0));
        repeat (12) begin
            gen(0, $urandom_range(1, 6));
            run_prog(0);
        end

        // Reset in the EXECUTE of a second instruction, after one commit moved the PC.
        c = 0; n = 0; pc = 0;
        st[0] = 1'b1;
        tick;
        for (int k = 0; k < 7; k++) begin
            garbage(0);
            {ie[0], iv[0], hl[0], ms[0], de[0]} = 5'b01000;
            np[0] = 64'h77;
            step(0, 5'(1 << (k % 5)), pc, 2'd0, c, n);
            if (k == 4) begin
                n = 1;
                pc = 64'h77;
            end
        end
        push(0, 5'b00100, pc, 2'd0, 1'b1, c, n);
        @(negedge clk);
        #2;
        reset = 1'b1;
        st[0] = 1'b1;
        #1;
        chk("async_reset", outs(0), pk(0, 64'h0, 0, 0, 0, 0));
        push(0, 5'b0, 64'h0, 2'd0, 1'b0, 0, 0);
        tick;
        chk("reset_over_start", outs(0), pk(0, 64'h0, 0, 0, 0, 0));
        reset = 1'b0;
        st[0] = 1'b0;
        tick;
        prog.delete(); add(64'h30, 1, 0, 0, 0, 0);
        run_prog(0);
        chk("mc_after_reset", outs(0), pk(0, 64'h0, 1, 0, 5, 1));

        prog.delete();
        for (int i = 0; i < 4; i++) add(64'h44 + 4 * i, 0, 0, 0, 0, 0);
        add(64'h0, 1, 0, 0, 0, 0);
        run_prog(1);
        chk("sc_halt", outs(1), pk(0, 64'h4C + 4, 1, 0, 5, 5));
        prog.delete(); add(64'h50, 0, 1, 0, 0, 0);
        run_prog(1);
        chk("sc_imem", outs(1), pk(0, 64'h40, 2, 0, 1, 0));
        prog.delete(); add(64'h60, 0, 0, 0, 0, 2); add(64'h0, 1, 0, 0, 0, 1);
        run_prog(1);
        chk("sc_stall", outs(1), pk(0, 64'h60, 1, 0, 5, 2));
        prog.delete();
        for (int i = 0; i < 20; i++) add(64'h44 + 4 * i, 0, 0, 0, 0, 0);
        add(64'h0, 1, 0, 0, 0, 0);
        run_prog(1);
        chk("sc_saturate", outs(1), pk(0, 64'h90, 1, 0, 15, 15));
        repeat (12) begin
            gen(1, $urandom_range(1, 8));
            run_prog(1);
        end

        repeat (3) tick;
        chk("q_mc_drained", 136'(q0.size()), 136'(0));
        chk("q_sc_drained", 136'(q1.size()), 136'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/y86_seq_sequencer.md
# y86_seq_sequencer

Parametrised instruction sequencer for the Y86-64 SEQ core. It replaces the free-running PC register and simulation-only halt in the processor top. It owns the PC, steps each instruction through fetch/decode/execute/memory/writeback using per-stage enable strobes (or one strobe per cycle in single-cycle mode), and records a Y86 status code. It stops cleanly on halt or fault, keeps cycle and retired-instruction counters, and waits on a data-memory stall.

## Interface
Parameters:
- ADDR_WIDTH, 64, width of PC and next_pc
- RESET_PC, 0, PC loaded at reset and on every start
- CNT_WIDTH, 32, width of cycle_count and instr_count
- SINGLE_CYCLE, 0, 1 = all stages enabled in one clock per instruction; 0 = one stage per clock

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  level; starts execution from IDLE or STOPPED
- next_pc  in  ADDR_WIDTH  PC-update result for the current instruction
- halt  in  1  fetch decoded halt (icode 0)
- instr_valid  in  1  fetch decoded a legal icode/ifun
- imem_error  in  1  fetch address out of range
- dmem_error  in  1  memory stage address out of range
- mem_stall  in  1  data memory not ready; hold in MEMORY
- pc  out  ADDR_WIDTH  current instruction address
- stage_en  out  5  one-hot {wb, mem, exe, dec, fet}; bit 0 = fetch
- stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS
- running  out  1  high in any state except IDLE and STOPPED
- cycle_count  out  CNT_WIDTH  clocks spent while running, saturating
- instr_count  out  CNT_WIDTH  instructions retired, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, STOPPED.
- Reset values (async): state IDLE, pc=RESET_PC, stat=AOK, counters 0, stage_en 0, running 0.
- IDLE: start=1 moves to FETCH; pc=RESET_PC, stat=AOK, counters cleared.
- stage_en drives the bit of the current state only. It is 0 in IDLE and STOPPED.
- FETCH: faults are checked in priority order.
  - imem_error: stat=ADR, go to STOPPED.
  - else !instr_valid: stat=INS, go to STOPPED.
  - else go to DECODE.
- Sequence DECODE → EXECUTE → MEMORY, unconditional.
- MEMORY: mem_stall=1 holds state; dmem_error is ignored while stalled.
  - Once mem_stall=0: dmem_error gives stat=ADR and STOPPED; otherwise go to WRITEBACK.
- WRITEBACK (commit): instr_count+1.
  - If halt was latched at FETCH: stat=HLT, go to STOPPED, pc unchanged.
  - Else pc=next_pc, go to FETCH.
- The halt flag is latched at the FETCH exit and cleared at commit.
- On a fault, pc keeps the faulting instruction's address and instr_count is not incremented.
- STOPPED: all outputs hold. start=1 behaves as in IDLE (restart from RESET_PC, stat AOK, counters cleared).
- SINGLE_CYCLE=1: the fetch→writeback sequence collapses into one RUN cycle.
  - stage_en=5'b11111.
  - All checks happen in the same cycle with priority imem_error > !instr_valid > mem_stall hold > dmem_error > halt > normal commit.
  - mem_stall holds pc and counters that cycle.
- cycle_count increments on every clock edge while running, including stall cycles and the final cycle that enters STOPPED. Both counters saturate at all-ones.
- start is ignored while running.

## Timing
- Multi-cycle mode: 5 clocks per instruction plus one per stall cycle. Single-cycle mode: 1 clock plus stalls.
- pc changes only on the WRITEBACK/RUN edge, or on start. It is valid the whole time an instruction is in flight.
- All fault and status inputs are sampled only on the edge that leaves the stage that checks them.
- stat and running update on the same edge that enters STOPPED.
- reset asserted mid-instruction forces the reset values immediately, regardless of clk, with no partial commit. Deassertion is synchronous to the next rising edge.
- start together with reset: reset wins.

## Test plan
- Multi-cycle, RESET_PC=0, next_pc=0x0A, then a halt at 0x0A:
  - Requires stage_en fet,dec,exe,mem,wb, pc 0→0x0A.
  - Ends with stat=HLT, pc=0x0A, instr_count=2, cycle_count=10, running=0.
- mem_stall=1 for 3 cycles in MEMORY: stage_en holds mem; the instruction completes on cycle 8; cycle_count=8 at commit.
- imem_error at FETCH with pc=0x40: stat=ADR, pc=0x40, instr_count=0, cycle_count=1.
- instr_valid=0 together with dmem_error=1 at FETCH: stat=INS, because FETCH checks have priority and dmem_error is not yet sampled.
- SINGLE_CYCLE=1, 4 plain instructions then halt: instr_count=5, cycle_count=5, stat=HLT, stage_en=5'b11111 while running.
- reset pulsed mid-EXECUTE, then start again: outputs return to reset values asynchronously; start gives pc=RESET_PC, counters 0, stat AOK.
